// File: rtl/spi_cmd_parser.sv
// spi_cmd_parser: assembles SUMP-style commands from the SPI byte receiver stream.
//   Short commands (opcode bit 7 clear) complete on the opcode byte alone.
//   Long commands (opcode bit 7 set) carry a 32-bit little-endian payload.
// Ports:
//   clock, reset_n      - system clock (rising edge), async active-low reset
//   rx_valid, rx_byte   - one-cycle received-byte strobe and its byte
//   cs_n                - synchronised chip select, high = deselected
//   cmd_valid           - one-cycle strobe, opcode/data/cmd_long describe a command
//   cmd_long, opcode    - command kind and opcode, held until the next cmd_valid
//   data                - long payload (first byte in [7:0]); 0 for short commands
//   busy                - a long command is partially received
//   abort               - one-cycle strobe, a partial long command was discarded
module spi_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TCW            = 13
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        cs_n,
    output logic        cmd_valid,
    output logic        cmd_long,
    output logic [7:0]  opcode,
    output logic [31:0] data,
    output logic        busy,
    output logic        abort
);

    localparam int unsigned PAYLOAD_BYTES = 4;
    localparam int unsigned BCW           = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [TCW-1:0]  tmo_q, tmo_d;
    logic [7:0]      long_op_q, long_op_d;
    logic [23:0]     payload_q, payload_d;
    logic            cmd_valid_d, cmd_long_d, busy_d, abort_d;
    logic [7:0]      opcode_d;
    logic [31:0]     data_d;

    logic last_byte_c;
    assign last_byte_c = (byte_cnt_q == BCW'(PAYLOAD_BYTES - 1));

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            long_op_q  <= '0;
            payload_q  <= '0;
            cmd_valid  <= 1'b0;
            cmd_long   <= 1'b0;
            opcode     <= '0;
            data       <= '0;
            busy       <= 1'b0;
            abort      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            long_op_q  <= long_op_d;
            payload_q  <= payload_d;
            cmd_valid  <= cmd_valid_d;
            cmd_long   <= cmd_long_d;
            opcode     <= opcode_d;
            data       <= data_d;
            busy       <= busy_d;
            abort      <= abort_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        tmo_d       = tmo_q;
        long_op_d   = long_op_q;
        payload_d   = payload_q;
        cmd_valid_d = 1'b0;
        cmd_long_d  = cmd_long;
        opcode_d    = opcode;
        data_d      = data;
        busy_d      = busy;
        abort_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // cs_n is ignored here: the receiver already validated the byte
                if (rx_valid) begin
                    if (!rx_byte[7]) begin
                        cmd_valid_d = 1'b1;
                        cmd_long_d  = 1'b0;
                        opcode_d    = rx_byte;
                        data_d      = '0;
                    end else begin
                        long_op_d  = rx_byte;
                        payload_d  = '0;
                        byte_cnt_d = '0;
                        tmo_d      = '0;
                        busy_d     = 1'b1;
                        state_d    = PAYLOAD;
                    end
                end
            end

            PAYLOAD: begin
                if (rx_valid) begin
                    // A received byte always wins over timeout and deselect
                    tmo_d = '0;
                    if (last_byte_c) begin
                        cmd_valid_d = 1'b1;
                        cmd_long_d  = 1'b1;
                        opcode_d    = long_op_q;
                        data_d      = {rx_byte, payload_q};
                        busy_d      = 1'b0;
                        byte_cnt_d  = '0;
                        state_d     = IDLE;
                    end else begin
                        case (byte_cnt_q)
                            2'd0:    payload_d[7:0]   = rx_byte;
                            2'd1:    payload_d[15:8]  = rx_byte;
                            default: payload_d[23:16] = rx_byte;
                        endcase
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                        if (cs_n) begin
                            abort_d    = 1'b1;
                            busy_d     = 1'b0;
                            byte_cnt_d = '0;
                            state_d    = IDLE;
                        end
                    end
                end else if (cs_n || (tmo_q == TCW'(TIMEOUT_CYCLES - 1))) begin
                    // Deselect, or this idle cycle brings the count to the limit
                    abort_d    = 1'b1;
                    busy_d     = 1'b0;
                    byte_cnt_d = '0;
                    tmo_d      = '0;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + TCW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_cmd_parser.sv
// tb_spi_cmd_parser: directed stimulus for spi_cmd_parser with a cycle-level
// reference model of the command rules and literal checks of captured commands.
module tb_spi_cmd_parser;

    localparam int unsigned TIMEOUT = 4096;

    logic        clock;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        cs_n;
    logic        cmd_valid;
    logic        cmd_long;
    logic [7:0]  opcode;
    logic [31:0] data;
    logic        busy;
    logic        abort;

    spi_cmd_parser #(.TIMEOUT_CYCLES(TIMEOUT), .TCW(13)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .cs_n      (cs_n),
        .cmd_valid (cmd_valid),
        .cmd_long  (cmd_long),
        .opcode    (opcode),
        .data      (data),
        .busy      (busy),
        .abort     (abort)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the outputs must be after each clock edge
    bit          m_in_long;
    logic [7:0]  m_op;
    logic [7:0]  m_bytes[$];
    int          m_silent;
    bit          e_valid, e_long, e_busy, e_abort;
    logic [7:0]  e_op;
    logic [31:0] e_data;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_in_long = 0; m_op = 0; m_bytes.delete(); m_silent = 0;
            e_valid = 0; e_long = 0; e_busy = 0; e_abort = 0; e_op = 0; e_data = 0;
        end else begin
            e_valid = 0;
            e_abort = 0;
            if (!m_in_long) begin
                if (rx_valid) begin
                    if (rx_byte < 8'h80) begin
                        e_valid = 1; e_long = 0; e_op = rx_byte; e_data = 0;
                    end else begin
                        m_in_long = 1; m_op = rx_byte; m_bytes.delete(); m_silent = 0;
                    end
                end
            end else if (rx_valid) begin
                m_bytes.push_back(rx_byte);
                m_silent = 0;
                if (m_bytes.size() == 4) begin
                    e_valid = 1; e_long = 1; e_op = m_op;
                    e_data = 32'(m_bytes[0]) + (32'(m_bytes[1]) << 8) +
                             (32'(m_bytes[2]) << 16) + (32'(m_bytes[3]) << 24);
                    m_in_long = 0;
                end else if (cs_n) begin
                    e_abort = 1; m_in_long = 0;
                end
            end else begin
                m_silent++;
                if (cs_n || m_silent == TIMEOUT) begin
                    e_abort = 1; m_in_long = 0;
                end
            end
            e_busy = m_in_long;
        end
    end

    // Compare every cycle and log completed commands for the literal checks
    logic [40:0] cmd_log[$];
    int          abort_seen = 0;

    always @(negedge clock) begin
        chk("cmd_valid", 32'(cmd_valid), 32'(e_valid));
        chk("abort",     32'(abort),     32'(e_abort));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("cmd_long",  32'(cmd_long),  32'(e_long));
        chk("opcode",    32'(opcode),    32'(e_op));
        chk("data",      data,           e_data);
        if (cmd_valid) cmd_log.push_back({cmd_long, opcode, data});
        if (abort) abort_seen++;
    end

    task automatic cyc(input logic v, input logic [7:0] b, input logic cs);
        @(posedge clock);
        #1;
        rx_valid = v;
        rx_byte  = b;
        cs_n     = cs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b, 1'b0);
    endtask

    task automatic expect_cmd(input string name, input logic lng, input logic [7:0] op,
                              input logic [31:0] d);
        logic [40:0] got;
        checks++;
        if (cmd_log.size() == 0) begin
            errors++;
            $display("FAIL %s: no command captured, expected long=%0d op=%h data=%h",
                     name, lng, op, d);
        end else begin
            got = cmd_log.pop_front();
            checks--;
            chk({name, "_long"}, 32'(got[40]),    32'(lng));
            chk({name, "_op"},   32'(got[39:32]), 32'(op));
            chk({name, "_data"}, got[31:0],       d);
        end
    endtask

    int ab0;

    initial begin
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        cs_n     = 1'b1;
        #1;
        chk("reset_cmd_valid", 32'(cmd_valid), 32'h0);
        chk("reset_busy",      32'(busy),      32'h0);
        chk("reset_data",      data,           32'h0);
        idle(3);
        reset_n = 1'b1;
        idle(2);

        // Short commands back to back
        send(8'h00); send(8'h00); send(8'h02);
        idle(3);
        expect_cmd("short0", 1'b0, 8'h00, 32'h0);
        expect_cmd("short1", 1'b0, 8'h00, 32'h0);
        expect_cmd("short2", 1'b0, 8'h02, 32'h0);

        // Long command
        send(8'h81); send(8'h0F); send(8'h00); send(8'h0F); send(8'h00);
        idle(3);
        expect_cmd("long81", 1'b1, 8'h81, 32'h000F000F);

        // Payload bytes that look like opcodes, back to back with a short command
        send(8'hC0); send(8'h00); send(8'h80); send(8'hC1); send(8'h02); send(8'h05);
        idle(3);
        expect_cmd("longC0", 1'b1, 8'hC0, 32'h02C18000);
        expect_cmd("short5", 1'b0, 8'h05, 32'h0);
        chk("no_extra_cmds", 32'(cmd_log.size()), 32'h0);

        // Timeout
        ab0 = abort_seen;
        send(8'h82); send(8'h00); send(8'h08);
        idle(TIMEOUT + 5);
        chk("timeout_abort_cnt", 32'(abort_seen - ab0), 32'd1);
        chk("timeout_no_cmd", 32'(cmd_log.size()), 32'h0);
        chk("timeout_busy", 32'(busy), 32'h0);
        send(8'h01);
        idle(2);
        expect_cmd("after_to", 1'b0, 8'h01, 32'h0);

        // Deselect together with the completing byte
        ab0 = abort_seen;
        send(8'hC2); send(8'h11); send(8'h22); send(8'h33);
        cyc(1'b1, 8'h44, 1'b1);
        idle(3);
        expect_cmd("cs_last", 1'b1, 8'hC2, 32'h44332211);
        chk("cs_last_no_abort", 32'(abort_seen - ab0), 32'd0);

        // Deselect after the second payload byte
        send(8'hC2); send(8'h11); send(8'h22);
        cyc(1'b0, 8'h00, 1'b1);
        idle(3);
        chk("cs_mid_abort_cnt", 32'(abort_seen - ab0), 32'd1);
        chk("cs_mid_no_cmd", 32'(cmd_log.size()), 32'h0);
        chk("cs_mid_opcode_held", 32'(opcode), 32'hC2);
        chk("cs_mid_data_held", data, 32'h44332211);

        // Reset in the middle of a long command
        ab0 = abort_seen;
        send(8'h80); send(8'h02);
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        chk("pre_reset_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_busy",   32'(busy),      32'h0);
        chk("rst_opcode", 32'(opcode),    32'h0);
        chk("rst_data",   data,           32'h0);
        chk("rst_long",   32'(cmd_long),  32'h0);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        send(8'h80); send(8'h02); send(8'h00); send(8'h00); send(8'h00);
        idle(3);
        expect_cmd("post_rst", 1'b1, 8'h80, 32'h00000002);
        chk("rst_no_abort", 32'(abort_seen - ab0), 32'd0);
        chk("final_log_empty", 32'(cmd_log.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
